rv32i_wb_top: RTL and testbench



---
 rtl/rv32i_pkg.sv | 30 +++
 rtl/rv32i_load_align.sv | 33 +++
 rtl/rv32i_wb_top.sv | 119 +++++++++++
 tb/tb_rv32i_wb_top.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I writeback stage.
//   - opcode constants used by writeback (LOAD, STORE, BRANCH, JAL, JALR)
//   - load funct3 encodings
//   - ECALL / EBREAK full instruction words
//   - writeback run/halt state encoding
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  localparam logic [31:0] IW_ECALL  = 32'h0000_0073;
  localparam logic [31:0] IW_EBREAK = 32'h0010_0073;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Load data extraction: picks the byte/halfword/word addressed by the low
// address bits and sign- or zero-extends it according to funct3.
//   word   : 32-bit source word (RAM or IO)
//   funct3 : load funct3 field
//   off    : address bits [1:0]
//   data   : extended load result; unknown funct3 yields 0
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    // halfword access only looks at off[1]; misaligned bit 0 is dropped
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'h0, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'h0, lane_h};
      F3_LW:   data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_wb_top.sv
// RV32I writeback stage.
// Consumes the memory stage's registered outputs plus RAM/IO read data,
// forms the register-file write (load extraction, link value, ALU result),
// mirrors it onto the decode forwarding path, and tracks RUN/HALT and the
// retired-instruction count. All outputs are registered (1-cycle latency).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wb_en_in, pc_in, iw_in, alu_in, wb_reg_in : memory-stage outputs
//   rdata, io_rdata       : RAM / IO read data, same cycle as *_in
//   rf_we/rf_waddr/rf_wdata : register-file write port
//   df_wb_*               : forwarding copy of the write port
//   halted                : set after a retired ECALL/EBREAK
//   instret               : 64-bit retired count
// Build option: define WB_INSTRET_EN to implement instret; otherwise it
// reads as zero.
module rv32i_wb_top
  import rv32i_pkg::*;
#(
  parameter logic [3:0]  IO_REGION    = 4'hF,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [4:0]  wb_reg_in,
  input  logic [31:0] rdata,
  input  logic [31:0] io_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        df_wb_enable,
  output logic [4:0]  df_wb_reg,
  output logic [31:0] df_wb_data,
  output logic        halted,
  output logic [63:0] instret
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] word;
  logic [31:0] load_data;
  logic [31:0] result;
  logic        run;
  logic        retire;
  logic        halt_req;
  logic        we_next;
  wb_state_t   state, state_next;

  assign opcode = iw_in[6:0];
  assign funct3 = iw_in[14:12];
  assign word   = (alu_in[31:28] == IO_REGION) ? io_rdata : rdata;

  rv32i_load_align u_align (
    .word   (word),
    .funct3 (funct3),
    .off    (alu_in[1:0]),
    .data   (load_data)
  );

  always_comb begin
    if (opcode == OP_LOAD)                          result = load_data;
    else if (opcode == OP_JAL || opcode == OP_JALR) result = pc_in + 32'd4;
    else                                            result = alu_in;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= WB_RUN;
    else       state <= state_next;
  end

  // next state: HALT is absorbing, only reset leaves it
  always_comb begin
    state_next = state;
    if (state == WB_RUN && halt_req) state_next = WB_HALT;
  end

  // FSM outputs
  always_comb begin
    run     = (state == WB_RUN);
    halted  = (state == WB_HALT);
    retire  = run && (iw_in != RESET_PC_TAG);
    halt_req = retire && (iw_in == IW_ECALL || iw_in == IW_EBREAK);
    we_next = run && wb_en_in && (wb_reg_in != 5'd0) &&
              (opcode != OP_STORE) && (opcode != OP_BRANCH);
  end

  // write port; address/data freeze while halted so the last write is visible
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'h0;
    end else begin
      rf_we <= we_next;
      if (run) begin
        rf_waddr <= wb_reg_in;
        rf_wdata <= result;
      end
    end
  end

  assign df_wb_enable = rf_we;
  assign df_wb_reg    = rf_waddr;
  assign df_wb_data   = rf_wdata;

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk) begin
    if (reset)       instret <= 64'h0;
    else if (retire) instret <= instret + 64'd1;
  end
`else
  assign instret = 64'h0;
`endif

endmodule

// File: tb/tb_rv32i_wb_top.sv
// Self-checking bench for rv32i_wb_top: directed vector table, hand-written
// halt/reset sequences, and randomized traffic against a behavioural model.
module tb_rv32i_wb_top;

`ifdef WB_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  typedef struct {
    logic        wb_en;
    logic [31:0] pc;
    logic [31:0] iw;
    logic [31:0] alu;
    logic [4:0]  wb_reg;
    logic [31:0] rd;
    logic [31:0] io;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en_in = 1'b0;
  logic [31:0] pc_in = '0, iw_in = '0, alu_in = '0, rdata = '0, io_rdata = '0;
  logic [4:0]  wb_reg_in = '0;
  logic        rf_we, df_wb_enable, halted;
  logic [4:0]  rf_waddr, df_wb_reg;
  logic [31:0] rf_wdata, df_wb_data;
  logic [63:0] instret;

  rv32i_wb_top dut (
    .clk(clk), .reset(reset), .wb_en_in(wb_en_in), .pc_in(pc_in), .iw_in(iw_in),
    .alu_in(alu_in), .wb_reg_in(wb_reg_in), .rdata(rdata), .io_rdata(io_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .df_wb_enable(df_wb_enable), .df_wb_reg(df_wb_reg), .df_wb_data(df_wb_data),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_halt = 1'b0;
  logic [63:0] m_instret = 64'h0;
  logic        e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  bit          e_chk_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic en, input logic [31:0] pc, input logic [31:0] iw,
                             input logic [31:0] alu, input logic [4:0] rg,
                             input logic [31:0] rd, input logic [31:0] io);
    in_t v;
    v.wb_en = en; v.pc = pc; v.iw = iw; v.alu = alu; v.wb_reg = rg; v.rd = rd; v.io = io;
    return v;
  endfunction

  // expected write data, straight from the load/link/ALU rules
  function automatic logic [31:0] ref_data(input in_t v);
    logic [31:0] w;
    logic [7:0]  bt;
    logic [15:0] hw;
    int          sh;
    w  = (v.alu[31:28] == 4'hF) ? v.io : v.rd;
    sh = 8 * int'(v.alu[1:0]);
    bt = 8'(w >> sh);
    hw = v.alu[1] ? 16'(w / 32'h10000) : 16'(w % 32'h10000);
    if (v.iw[6:0] == 7'h03) begin
      case (v.iw[14:12])
        3'd0:    return 32'($signed(bt));
        3'd4:    return 32'(bt);
        3'd1:    return 32'($signed(hw));
        3'd5:    return 32'(hw);
        3'd2:    return w;
        default: return 32'h0;
      endcase
    end
    if (v.iw[6:0] == 7'h6F || v.iw[6:0] == 7'h67) return v.pc + 32'd4;
    return v.alu;
  endfunction

  // one cycle: drive, advance the model, clock, compare everything
  task automatic step(input in_t v, input bit rst);
    logic [6:0] op;
    wb_en_in = v.wb_en; pc_in = v.pc; iw_in = v.iw; alu_in = v.alu;
    wb_reg_in = v.wb_reg; rdata = v.rd; io_rdata = v.io; reset = rst;
    op = v.iw[6:0];
    if (rst) begin
      e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'h0; e_chk_addr = 1'b1;
      m_halt = 1'b0; m_instret = 64'h0;
    end else begin
      e_we = v.wb_en && v.wb_reg != 5'd0 && op != 7'h23 && op != 7'h63 && !m_halt;
      e_chk_addr = e_we;
      e_waddr = v.wb_reg;
      e_wdata = ref_data(v);
      if (!m_halt && v.iw != 32'h0) begin
        m_instret = m_instret + 64'd1;
        if (v.iw == 32'h0000_0073 || v.iw == 32'h0010_0073) m_halt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rf_we", rf_we, e_we);
    chk("df_wb_enable", df_wb_enable, e_we);
    if (e_chk_addr) begin
      chk("rf_waddr", rf_waddr, e_waddr);
      chk("rf_wdata", rf_wdata, e_wdata);
      chk("df_wb_reg", df_wb_reg, e_waddr);
      chk("df_wb_data", df_wb_data, e_wdata);
    end
    chk("halted", halted, m_halt);
    chk("instret", instret, INSTRET_ON ? m_instret : 64'h0);
  endtask

  function automatic logic [63:0] ir(input int n);
    return INSTRET_ON ? 64'(n) : 64'h0;
  endfunction

  vec_t vt[$];
  in_t  add_op;
  in_t  v;
  logic [31:0] r;
  logic [6:0]  ops[8];

  initial begin
    // directed table
    vt.push_back('{"lb",       mk(1, 0, 32'h0000_0003, 32'h0000_1003, 5,  32'h80FF_1234, 0), 1, 5,  32'hFFFF_FF80});
    vt.push_back('{"lbu",      mk(1, 0, 32'h0000_4003, 32'h0000_1003, 5,  32'h80FF_1234, 0), 1, 5,  32'h0000_0080});
    vt.push_back('{"lhu_io",   mk(1, 0, 32'h0000_5003, 32'hF000_0002, 9,  32'h0, 32'hBEEF_0000), 1, 9, 32'h0000_BEEF});
    vt.push_back('{"lh_odd",   mk(1, 0, 32'h0000_1003, 32'h0000_0003, 3,  32'h8001_0000, 0), 1, 3,  32'hFFFF_8001});
    vt.push_back('{"lw",       mk(1, 0, 32'h0000_2003, 32'h0000_0101, 4,  32'h1234_5678, 0), 1, 4,  32'h1234_5678});
    vt.push_back('{"ld_bad",   mk(1, 0, 32'h0000_3003, 32'h0000_0000, 6,  32'hFFFF_FFFF, 0), 1, 6,  32'h0});
    vt.push_back('{"jal_wrap", mk(1, 32'hFFFF_FFFC, 32'h0000_006F, 0, 1, 0, 0), 1, 1, 32'h0});
    vt.push_back('{"jal_x0",   mk(1, 32'hFFFF_FFFC, 32'h0000_006F, 0, 0, 0, 0), 0, 0, 32'h0});
    vt.push_back('{"store",    mk(1, 0, 32'h0000_2023, 32'h10, 7, 0, 0), 0, 0, 32'h0});
    vt.push_back('{"bubble",   mk(0, 0, 32'h0, 0, 0, 0, 0), 0, 0, 32'h0});
    vt.push_back('{"add",      mk(1, 0, 32'h0000_0033, 32'hDEAD_BEEF, 31, 0, 0), 1, 31, 32'hDEAD_BEEF});

    add_op = mk(1, 32'h100, 32'h0000_0033, 32'h0000_00AA, 2, 0, 0);

    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("reset_we", rf_we, 1'b0);
    chk("reset_wdata", rf_wdata, 32'h0);
    chk("reset_instret", instret, 64'h0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].in, 1'b0);
      chk({"tbl_we_", vt[i].name}, rf_we, vt[i].we);
      if (vt[i].we) begin
        chk({"tbl_waddr_", vt[i].name}, rf_waddr, vt[i].waddr);
        chk({"tbl_wdata_", vt[i].name}, rf_wdata, vt[i].wdata);
      end
    end
    // 10 non-bubble entries retired
    chk("tbl_instret", instret, ir(10));

    // halt sequence: three ALU ops then EBREAK
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 3; i++) step(add_op, 1'b0);
    step(mk(0, 32'h10C, 32'h0010_0073, 0, 0, 0, 0), 1'b0);
    chk("ebreak_halted", halted, 1'b1);
    chk("ebreak_instret", instret, ir(4));
    step(add_op, 1'b0);
    chk("halt_add_we", rf_we, 1'b0);
    chk("halt_add_instret", instret, ir(4));
    chk("halt_sticky", halted, 1'b1);

    // reset while halted
    step(add_op, 1'b1);
    chk("rst_halt_halted", halted, 1'b0);
    chk("rst_halt_instret", instret, 64'h0);
    chk("rst_halt_we", rf_we, 1'b0);
    step(add_op, 1'b0);
    chk("post_rst_we", rf_we, 1'b1);
    chk("post_rst_wdata", rf_wdata, 32'h0000_00AA);
    chk("post_rst_instret", instret, ir(1));

    // ECALL halts too; mid-flight reset discards the instruction
    step(mk(1, 0, 32'h0000_0073, 0, 3, 0, 0), 1'b0);
    chk("ecall_halted", halted, 1'b1);
    chk("ecall_instret", instret, ir(2));
    step(add_op, 1'b1);
    chk("rst_inflight_we", rf_we, 1'b0);
    chk("rst_inflight_instret", instret, 64'h0);

    // randomized traffic
    ops = '{7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13};
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      v.wb_en  = 1'($urandom_range(0, 3) != 0);
      v.pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      v.iw     = {r[31:7], ops[$urandom_range(0, 7)]};
      v.alu    = $urandom();
      if ($urandom_range(0, 2) == 0) v.alu[31:28] = 4'hF;
      v.wb_reg = 5'($urandom_range(0, 31));
      v.rd     = $urandom();
      v.io     = $urandom();
      if ($urandom_range(0, 9) == 0) v.iw = 32'h0;
      if ($urandom_range(0, 79) == 0) v.iw = ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h0010_0073;
      step(v, $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
